riscv_fetch_stage: RTL

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register and feeds the decode/register-read stage of the pipelined RISC-V core. It owns the PC and issues requests to a synchronous instruction memory. A small buffer absorbs the in-flight response when decode stalls, and a redirect from EX (taken branch) flushes the fetch path. Decode sees a valid/ready stream of {pc, ir}; when nothing is valid, the stream carries NOP.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/riscv_fetch_stage_buffer.sv | 45 ++++
 rtl/riscv_fetch_stage.sv | 93 +++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: widths, NOP encoding, major opcodes and
// the {pc, ir} bundle handed from fetch to decode.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_LW  = 7'b000_0011;
  localparam logic [6:0] OPC_SW  = 7'b010_0011;
  localparam logic [6:0] OPC_BEQ = 7'b110_0011;
  localparam logic [6:0] OPC_ALU = 7'b011_0011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     ir;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_stage_buffer.sv
// fetch_buffer: synchronous FIFO, clear has priority over push/pop.
// Ports: push/wdata, pop/rdata (head), clear, count, full, empty.
module fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  input  logic          clear,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wp] <= wdata;
  end

  assign rdata = mem[rp];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/riscv_fetch_stage.sv
// riscv_fetch_stage: PC, imem request, response buffer, EX redirect.
// Ports: clk, rst_n, imem_req/addr/rdata, redirect_valid/pc, ifid_*.
module riscv_fetch_stage #(
  parameter int              XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ifid_valid,
  input  logic            ifid_ready,
  output logic [31:0]     ifid_ir,
  output logic [XLEN-1:0] ifid_pc
);

  import riscv_pkg::NOP;

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int W  = XLEN + 32;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] issued;
  logic            inflight;
  logic            drop;
  logic            push;
  logic            pop;
  logic            room;
  logic [CW:0]     occ;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic [W-1:0]    head;
  logic            unused;

  assign ifid_valid = !empty;
  assign pop        = ifid_valid && ifid_ready;

  // Slots already promised: buffered + response on the bus - head leaving.
  assign occ  = {1'b0, count}
              + {{CW{1'b0}}, inflight}
              - {{CW{1'b0}}, pop};
  assign room = occ < (CW+1)'(BUF_DEPTH);

  assign imem_req  = rst_n && (room || redirect_valid);
  assign imem_addr = redirect_valid
                   ? {redirect_pc[XLEN-1:2], 2'b00}
                   : pc;

  // The response arriving during a redirect is from the old path.
  assign drop = redirect_valid;
  assign push = inflight && !drop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      issued   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pc     <= imem_addr + XLEN'(4);
        issued <= imem_addr;
      end
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .W     (W)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({issued, imem_rdata}),
    .pop   (pop && !redirect_valid),
    .clear (redirect_valid),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign ifid_ir = ifid_valid ? head[31:0] : NOP;
  assign ifid_pc = ifid_valid ? head[W-1:32] : '0;

  assign unused = ^{redirect_pc[1:0], full};

endmodule
